// File: rtl/cpu_mem_responder.sv
// CPU memory responder: serves CPU accesses from a 2 KiB internal RAM
// (0x0000-0x1FFF, mirrored 4x) after a programmable number of wait states,
// and forwards every other address to an external request/ack bus guarded
// by a timeout that forces an acknowledge when the bus never answers.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for memreq; decodes the address and launches an access
// RAM   | internal access, wait counter running down to 0
// EXT   | external access, extreq high until extack or timeout
// ACK   | memack high for this single cycle; no new request accepted
module cpu_mem_responder #(
    parameter int WAIT    = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] memaddr,
    input  logic [7:0]  memwdata,
    input  logic        memwr,
    input  logic        memreq,
    output logic [7:0]  memrdata,
    output logic        memack,
    output logic [15:0] extaddr,
    output logic [7:0]  extwdata,
    output logic        extwr,
    output logic        extreq,
    input  logic [7:0]  extrdata,
    input  logic        extack
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT);
    localparam logic [7:0] TOUT_LD = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        RAM,
        EXT,
        ACK
    } state_t;

    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic [7:0]  tout_cnt_q;
    logic [10:0] ram_addr_q;
    logic [7:0]  ram_wdata_q;
    logic        ram_wr_q;
    logic [7:0]  memrdata_q;
    logic        memack_q;
    logic [15:0] extaddr_q;
    logic [7:0]  extwdata_q;
    logic        extwr_q;
    logic        extreq_q;
    logic [7:0]  ram_q [0:2047];
    logic        ram_we_d;

    // The RAM access fires on the edge that leaves RAM with the counter at 0.
    // Reset holds state_q in IDLE, so an abandoned access can never write.
    assign ram_we_d = (state_q == RAM) && (wait_cnt_q == 4'd0) && ram_wr_q;

    assign memrdata = memrdata_q;
    assign memack   = memack_q;
    assign extaddr  = extaddr_q;
    assign extwdata = extwdata_q;
    assign extwr    = extwr_q;
    assign extreq   = extreq_q;

    // Internal RAM storage; deliberately not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_d) begin
            ram_q[ram_addr_q] <= ram_wdata_q;
        end
    end

    // Access sequencer with registered CPU and external-bus outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            tout_cnt_q  <= 8'd0;
            ram_addr_q  <= 11'd0;
            ram_wdata_q <= 8'd0;
            ram_wr_q    <= 1'b0;
            memrdata_q  <= 8'd0;
            memack_q    <= 1'b0;
            extaddr_q   <= 16'd0;
            extwdata_q  <= 8'd0;
            extwr_q     <= 1'b0;
            extreq_q    <= 1'b0;
        end else begin
            memack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (memreq) begin
                        if (memaddr < 16'h2000) begin
                            // Request is captured so a falling memreq cannot disturb it.
                            state_q     <= RAM;
                            wait_cnt_q  <= WAIT_LD;
                            ram_addr_q  <= memaddr[10:0];
                            ram_wdata_q <= memwdata;
                            ram_wr_q    <= memwr;
                        end else begin
                            state_q    <= EXT;
                            tout_cnt_q <= TOUT_LD;
                            extaddr_q  <= memaddr;
                            extwdata_q <= memwdata;
                            extwr_q    <= memwr;
                            extreq_q   <= 1'b1;
                        end
                    end
                end
                RAM: begin
                    if (wait_cnt_q == 4'd0) begin
                        if (!ram_wr_q) begin
                            memrdata_q <= ram_q[ram_addr_q];
                        end
                        memack_q <= 1'b1;
                        state_q  <= ACK;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                EXT: begin
                    // extack wins over a timeout expiring in the same cycle.
                    if (extack) begin
                        if (!extwr_q) begin
                            memrdata_q <= extrdata;
                        end
                        extreq_q   <= 1'b0;
                        tout_cnt_q <= 8'd0;
                        memack_q   <= 1'b1;
                        state_q    <= ACK;
                    end else if (tout_cnt_q <= 8'd1) begin
                        // Counter reaches 0 on this edge: open bus, memrdata kept.
                        extreq_q   <= 1'b0;
                        tout_cnt_q <= 8'd0;
                        memack_q   <= 1'b1;
                        state_q    <= ACK;
                    end else begin
                        tout_cnt_q <= tout_cnt_q - 8'd1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: one instance with WAIT=1/TIMEOUT=4 for the
// single-access scenarios, one with WAIT=0 for back-to-back throughput.
module tb_cpu_mem_responder;

    localparam int WAIT_A = 1;
    localparam int TOUT_A = 4;

    typedef struct {
        logic [7:0] rdata;
        int         cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] memaddr;
    logic [7:0]  memwdata;
    logic        memwr;
    logic        memreq;
    logic [7:0]  memrdata;
    logic        memack;
    logic [15:0] extaddr;
    logic [7:0]  extwdata;
    logic        extwr;
    logic        extreq;
    logic [7:0]  extrdata;
    logic        extack;

    logic [15:0] b_memaddr;
    logic [7:0]  b_memwdata;
    logic        b_memwr;
    logic        b_memreq;
    logic [7:0]  b_memrdata;
    logic        b_memack;
    logic [15:0] b_extaddr;
    logic [7:0]  b_extwdata;
    logic        b_extwr;
    logic        b_extreq;
    logic [7:0]  b_extrdata;
    logic        b_extack;

    int          cyc;
    int          n_checks;
    int          n_errors;
    exp_t        sb_q[$];
    logic [7:0]  mem_model [0:2047];
    logic [7:0]  model_rdata;

    cpu_mem_responder #(.WAIT(WAIT_A), .TIMEOUT(TOUT_A)) u_dut (
        .clk(clk), .reset(rst_n),
        .memaddr(memaddr), .memwdata(memwdata), .memwr(memwr), .memreq(memreq),
        .memrdata(memrdata), .memack(memack),
        .extaddr(extaddr), .extwdata(extwdata), .extwr(extwr), .extreq(extreq),
        .extrdata(extrdata), .extack(extack)
    );

    cpu_mem_responder #(.WAIT(0), .TIMEOUT(255)) u_b2b (
        .clk(clk), .reset(rst_n),
        .memaddr(b_memaddr), .memwdata(b_memwdata), .memwr(b_memwr), .memreq(b_memreq),
        .memrdata(b_memrdata), .memack(b_memack),
        .extaddr(b_extaddr), .extwdata(b_extwdata), .extwr(b_extwr), .extreq(b_extreq),
        .extrdata(b_extrdata), .extack(b_extack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Every memack pulse pops one expected completion: data and the cycle it must land on.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && memack === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ack_rdata", 32'(memrdata), 32'(e.rdata));
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // lat = edge (counted from accept) at which extack is sampled; 0 = never.
    task automatic cpu_access(input logic [15:0] addr, input logic wr, input logic [7:0] wdata,
                              input int lat, input logic [7:0] xdata, input logic drop);
        exp_t e;
        int   acc;
        int   xcnt;
        bit   is_int;
        bit   done;
        is_int = (addr < 16'h2000);
        xcnt   = 0;
        done   = 1'b0;
        @(negedge clk);
        memaddr  = addr;
        memwr    = wr;
        memwdata = wdata;
        memreq   = 1'b1;
        extrdata = xdata;
        acc      = cyc + 1;
        if (is_int) begin
            e.cyc = acc + WAIT_A + 1;
            if (wr) mem_model[addr[10:0]] = wdata;
            else    model_rdata = mem_model[addr[10:0]];
        end else if (lat < 1 || lat > TOUT_A) begin
            e.cyc = acc + TOUT_A;
        end else begin
            e.cyc = acc + lat;
            if (!wr) model_rdata = xdata;
        end
        e.rdata = model_rdata;
        sb_q.push_back(e);
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (memack) begin
                memreq = 1'b0;
                extack = 1'b0;
                done   = 1'b1;
            end else begin
                if (extreq) xcnt++;
                if (cyc == acc) begin
                    check("extreq_level", 32'(extreq), 32'(!is_int));
                    if (!is_int) begin
                        check("extaddr", 32'(extaddr), 32'(addr));
                        check("extwr", 32'(extwr), 32'(wr));
                        if (wr) check("extwdata", 32'(extwdata), 32'(wdata));
                    end
                end
                if (drop && cyc == acc + 1) memreq = 1'b0;
                extack = (!is_int && lat >= 1 && cyc == acc + lat - 1);
            end
        end
        check("ack_seen", 32'(done), 32'd1);
        check("extreq_cycles", 32'(xcnt), is_int ? 32'd0 : 32'(e.cyc - acc));
    endtask

    // Back-to-back on the WAIT=0 instance: acks must land every 3 cycles.
    task automatic b2b(input logic wr);
        int c0;
        int k;
        k = 0;
        @(negedge clk);
        b_memaddr  = 16'h0000;
        b_memwr    = wr;
        b_memwdata = 8'hA0;
        b_memreq   = 1'b1;
        c0         = cyc;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (b_memack) begin
                check("b2b_ack_cyc", 32'(cyc), 32'(c0 + 2 + 3 * k));
                check("b2b_rdata", 32'(b_memrdata), wr ? 32'h00 : 32'(8'hA0 + 8'(k)));
                k++;
                if (k < 3) begin
                    b_memaddr  = 16'(k);
                    b_memwdata = 8'hA0 + 8'(k);
                end else begin
                    b_memreq = 1'b0;
                end
            end
        end
        check("b2b_ack_count", 32'(k), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc = 0; n_checks = 0; n_errors = 0; model_rdata = 8'h00;
        rst_n = 1'b0;
        memaddr = '0; memwdata = '0; memwr = 1'b0; memreq = 1'b0;
        extrdata = '0; extack = 1'b0;
        b_memaddr = '0; b_memwdata = '0; b_memwr = 1'b0; b_memreq = 1'b0;
        b_extrdata = '0; b_extack = 1'b0;

        #12;
        check("rst_memack", 32'(memack), 32'd0);
        check("rst_extreq", 32'(extreq), 32'd0);
        check("rst_extwr", 32'(extwr), 32'd0);
        check("rst_extaddr", 32'(extaddr), 32'd0);
        check("rst_extwdata", 32'(extwdata), 32'd0);
        check("rst_memrdata", 32'(memrdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read through a mirror address.
        cpu_access(16'h0042, 1'b1, 8'h5A, 0, 8'h00, 1'b0);
        cpu_access(16'h1842, 1'b0, 8'h00, 0, 8'h00, 1'b0);
        // External read with no answer: timeout, open bus keeps 0x5A.
        cpu_access(16'h4000, 1'b0, 8'h00, 0, 8'h00, 1'b0);
        // External read answered 3 cycles after extreq rises.
        cpu_access(16'h8000, 1'b0, 8'h00, 3, 8'hC3, 1'b0);
        // extack on the very edge the timeout expires: data still taken.
        cpu_access(16'hF000, 1'b0, 8'h00, 4, 8'h3C, 1'b0);
        // External write with memreq dropped early: completes, rdata unchanged.
        cpu_access(16'h6000, 1'b1, 8'h77, 3, 8'h99, 1'b1);

        // Stray extack while idle must not ack or change memrdata.
        @(negedge clk);
        extack = 1'b1; extrdata = 8'hEE;
        @(negedge clk);
        extack = 1'b0;
        @(negedge clk);
        check("idle_extack_rdata", 32'(memrdata), 32'(model_rdata));

        // Reset in the middle of a RAM write: old contents survive.
        cpu_access(16'h0100, 1'b1, 8'h11, 0, 8'h00, 1'b0);
        @(negedge clk);
        memaddr = 16'h0100; memwr = 1'b1; memwdata = 8'h22; memreq = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ram_memack", 32'(memack), 32'd0);
        check("rst_ram_memrdata", 32'(memrdata), 32'd0);
        memreq = 1'b0; model_rdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        cpu_access(16'h0100, 1'b0, 8'h00, 0, 8'h00, 1'b0);

        // Reset in the middle of an external access drops extreq at once.
        @(negedge clk);
        memaddr = 16'h9000; memwr = 1'b0; memreq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ext_before_rst", 32'(extreq), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ext_extreq", 32'(extreq), 32'd0);
        check("rst_ext_memack", 32'(memack), 32'd0);
        memreq = 1'b0; model_rdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        cpu_access(16'h0042, 1'b0, 8'h00, 0, 8'h00, 1'b0);

        b2b(1'b1);
        b2b(1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
